game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game state controller that produces the 4-bit game state consumed by the pixel compositor and enemy logic. It sequences start screen, the four difficulty levels (auto-escalating on survival time), life loss on collision, and the failure screen, all paced by a once-per-frame tick. It also exports lives, score and per-level enemy spawn period.

## Interface
- LEVEL_FRAMES, 600: frame ticks survived before escalating to the next level.
- LIVES, 3: lives at game start (legal 1..3).
- INVULN_FRAMES, 60: frame ticks of hit immunity after losing a life.
- FAIL_HOLD_FRAMES, 120: frame ticks the failure screen ignores start.

- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  one-cycle debounced start-button pulse.
- hit  in  1  one-cycle player/enemy collision pulse.
- pause  in  1  level pause request (used only with GAME_SEQUENCER_PAUSE_EN).
- state  out  4  GAMESTART=0, EASY=1, NORMAL=2, HARD=3, INFERNO=4, FAILURE=5.
- lives  out  2  remaining lives.
- score  out  16  frames survived in current game, saturating.
- spawn_period  out  8  frames between enemy spawns for current level.
- invuln  out  1  high while immunity counter nonzero.
- paused  out  1  high while play is frozen.

## Operation
- Reset values: state=GAMESTART, lives=0, score=0, spawn_period=0, invuln=0, paused=0; all internal counters 0.
- GAMESTART: start -> EASY; lives loaded to LIVES, score, level counter, invuln counter cleared. hit, frame_tick ignored.
- Playing states (EASY..INFERNO), on each frame_tick: score += 1 (saturate at 16'hFFFF); level counter += 1; invuln counter -= 1 if nonzero. When level counter is at LEVEL_FRAMES-1 on a tick: clear it, advance EASY->NORMAL->HARD->INFERNO. In INFERNO the counter wraps, no advance.
- hit in playing state with invuln counter 0: lives -= 1, invuln counter loaded INVULN_FRAMES. If lives was 1: lives=0, state -> FAILURE, fail-hold counter loaded FAIL_HOLD_FRAMES. hit with invuln counter nonzero: ignored.
- start during play: ignored.
- FAILURE: fail-hold counter decrements on frame_tick. start accepted only when counter is 0 -> GAMESTART (never directly to EASY). score and lives hold their final values until next game start.
- spawn_period: EASY 60, NORMAL 40, HARD 25, INFERNO 15, GAMESTART/FAILURE 0.
- Simultaneous events same cycle: fatal hit beats level escalation (go to FAILURE, level unchanged); non-fatal hit and escalation both apply; frame_tick and hit together: counters tick and hit is judged against invuln value before that tick's decrement.

## Timing
- All outputs registered; state, lives, score, counters update on the clk edge after the triggering pulse (1-cycle latency).
- spawn_period and invuln are registered from next-state values, so they change the same edge as state/counter.
- rst asserted mid-game: immediate return to reset values regardless of state; no pending event survives.
- Inputs are single-cycle pulses; a pulse held multiple cycles counts once per cycle high.

## Configuration
- GAME_SEQUENCER_PAUSE_EN defined: pause high in a playing state sets paused=1 next edge; while paused, frame_tick and hit are ignored, state/counters frozen; pause low resumes next edge. pause ignored in GAMESTART/FAILURE (paused=0).
- Not defined: pause port present but ignored; paused tied 0.

## Structure
- Shared package game_pkg: state encodings (GAMESTART..FAILURE), 4-bit state width, per-level spawn-period constants; compositor and enemy logic import the same encodings.
- One sub-module: tick_counter (loadable down/up counter advancing on frame_tick with enable), instantiated for level, invuln and fail-hold counters.

## Test plan
- Reset, then start -> state=1, lives=3, score=0, spawn_period=60 one cycle later.
- 600 frame_ticks in EASY -> state=2, spawn_period=40; 1800 total -> state=4, then 600 more -> state stays 4.
- hit at t, second hit 30 ticks later -> lives 3->2 only, invuln=1; hit after 60 ticks -> lives=1.
- Three hits spaced >60 ticks -> state=5, lives=0; start after 50 ticks ignored; start after 120 ticks -> state=0.
- Fatal hit on same cycle as 600th tick in EASY -> state=5, not 2.
- With GAME_SEQUENCER_PAUSE_EN: pause for 100 ticks plus hits -> score, lives, state unchanged, paused=1; release -> counting resumes.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared game-state encodings and per-level constants for the
// sequencer, pixel compositor and enemy logic.
// Exports: state width/encodings, spawn periods, is_play()/spawn_for() helpers.
package game_pkg;

    localparam int STATE_W = 4;

    // Legacy-compatible state encodings consumed by downstream blocks.
    localparam logic [STATE_W-1:0] ST_GAMESTART = 4'd0;
    localparam logic [STATE_W-1:0] ST_EASY      = 4'd1;
    localparam logic [STATE_W-1:0] ST_NORMAL    = 4'd2;
    localparam logic [STATE_W-1:0] ST_HARD      = 4'd3;
    localparam logic [STATE_W-1:0] ST_INFERNO   = 4'd4;
    localparam logic [STATE_W-1:0] ST_FAILURE   = 4'd5;

    // Frames between enemy spawns, per level.
    localparam logic [7:0] SPAWN_EASY    = 8'd60;
    localparam logic [7:0] SPAWN_NORMAL  = 8'd40;
    localparam logic [7:0] SPAWN_HARD    = 8'd25;
    localparam logic [7:0] SPAWN_INFERNO = 8'd15;

    function automatic logic is_play(input logic [STATE_W-1:0] st);
        return (st == ST_EASY) || (st == ST_NORMAL) ||
               (st == ST_HARD) || (st == ST_INFERNO);
    endfunction

    function automatic logic [7:0] spawn_for(input logic [STATE_W-1:0] st);
        logic [7:0] sp;
        case (st)
            ST_EASY:    sp = SPAWN_EASY;
            ST_NORMAL:  sp = SPAWN_NORMAL;
            ST_HARD:    sp = SPAWN_HARD;
            ST_INFERNO: sp = SPAWN_INFERNO;
            default:    sp = 8'd0;
        endcase
        return sp;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// tick_counter: loadable frame counter; counts up (wrapping) or down
// (stopping at zero) on each enabled tick. Load has priority over tick.
// Ports: clk/rst, tick_i, load_i, load_val_i -> cnt_o (current), nxt_o (next).
module tick_counter
    import game_pkg::*;
#(
    parameter int W  = 8,
    parameter bit UP = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] nxt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i) begin
            if (UP) begin
                cnt_d = cnt_q + 1'b1;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign nxt_o = cnt_d;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: game state controller (start screen, four auto-escalating
// levels, lives/invulnerability, failure screen) paced by frame_tick.
// Ports: clk, rst, frame_tick, start, hit, pause -> state, lives, score,
// spawn_period, invuln, paused. All outputs registered, 1-cycle latency.
// Build option: GAME_SEQUENCER_PAUSE_EN enables the level pause; otherwise
// pause is ignored and paused is held at 0.
module game_sequencer
    import game_pkg::*;
#(
    parameter int LEVEL_FRAMES     = 600,
    parameter int LIVES            = 3,
    parameter int INVULN_FRAMES    = 60,
    parameter int FAIL_HOLD_FRAMES = 120
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               hit,
    input  logic               pause,
    output logic [STATE_W-1:0] state,
    output logic [1:0]         lives,
    output logic [15:0]        score,
    output logic [7:0]         spawn_period,
    output logic               invuln,
    output logic               paused
);

    localparam int LVL_W  = $clog2(LEVEL_FRAMES + 1);
    localparam int INV_W  = $clog2(INVULN_FRAMES + 1);
    localparam int FAIL_W = $clog2(FAIL_HOLD_FRAMES + 1);

    localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(LEVEL_FRAMES - 1);
    localparam logic [INV_W-1:0]  INV_LOAD  = INV_W'(INVULN_FRAMES);
    localparam logic [FAIL_W-1:0] FAIL_LOAD = FAIL_W'(FAIL_HOLD_FRAMES);

    logic [STATE_W-1:0] state_q, state_d;
    logic [1:0]         lives_q, lives_d;
    logic [15:0]        score_q, score_d;
    logic [7:0]         spawn_q;
    logic               invuln_q;
    logic               paused_q, paused_d;

    logic [LVL_W-1:0]   lvl_cnt, lvl_nxt;
    logic [INV_W-1:0]   inv_cnt, inv_nxt;
    logic [FAIL_W-1:0]  fail_cnt, fail_nxt;

    logic               active;
    logic               tick_play;
    logic               hit_ok;
    logic               fatal;
    logic               lvl_wrap;
    logic               new_game;
    logic               fail_tick;

    // Play advances only in a level state and, when pause is built in,
    // only while not frozen.
`ifdef GAME_SEQUENCER_PAUSE_EN
    assign active = is_play(state_q) && !paused_q;
`else
    assign active = is_play(state_q);
`endif

    assign tick_play = frame_tick && active;
    // Hit judged against the pre-tick immunity value.
    assign hit_ok    = hit && active && (inv_cnt == '0);
    assign fatal     = hit_ok && (lives_q == 2'd1);
    assign lvl_wrap  = tick_play && (lvl_cnt == LVL_LAST);
    assign new_game  = start && (state_q == ST_GAMESTART);
    assign fail_tick = frame_tick && (state_q == ST_FAILURE);

    // Survival time within the current level; wraps in INFERNO.
    tick_counter #(.W(LVL_W), .UP(1'b1)) u_level_cnt (
        .clk        (clk),
        .rst        (rst),
        .tick_i     (tick_play),
        .load_i     (new_game || lvl_wrap),
        .load_val_i ('0),
        .cnt_o      (lvl_cnt),
        .nxt_o      (lvl_nxt)
    );

    // Immunity after a non-fatal hit; a fatal hit clears it so the
    // failure screen never shows the player as invulnerable.
    tick_counter #(.W(INV_W), .UP(1'b0)) u_invuln_cnt (
        .clk        (clk),
        .rst        (rst),
        .tick_i     (tick_play),
        .load_i     (new_game || hit_ok),
        .load_val_i ((hit_ok && !fatal) ? INV_LOAD : '0),
        .cnt_o      (inv_cnt),
        .nxt_o      (inv_nxt)
    );

    // Failure-screen hold before start is honoured again.
    tick_counter #(.W(FAIL_W), .UP(1'b0)) u_fail_cnt (
        .clk        (clk),
        .rst        (rst),
        .tick_i     (fail_tick),
        .load_i     (fatal),
        .load_val_i (FAIL_LOAD),
        .cnt_o      (fail_cnt),
        .nxt_o      (fail_nxt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_GAMESTART: begin
                if (start) begin
                    state_d = ST_EASY;
                end
            end
            ST_EASY, ST_NORMAL, ST_HARD, ST_INFERNO: begin
                // A fatal hit overrides any escalation on the same cycle.
                if (fatal) begin
                    state_d = ST_FAILURE;
                end else if (lvl_wrap && (state_q != ST_INFERNO)) begin
                    state_d = state_q + 1'b1;
                end
            end
            ST_FAILURE: begin
                if (start && (fail_cnt == '0)) begin
                    state_d = ST_GAMESTART;
                end
            end
            default: state_d = ST_GAMESTART;
        endcase
    end

    always_comb begin
        lives_d = lives_q;
        score_d = score_q;
        if (new_game) begin
            lives_d = 2'(LIVES);
            score_d = '0;
        end else begin
            if (hit_ok) begin
                lives_d = lives_q - 1'b1;
            end
            if (tick_play && (score_q != 16'hFFFF)) begin
                score_d = score_q + 1'b1;
            end
        end
    end

    always_comb begin
`ifdef GAME_SEQUENCER_PAUSE_EN
        paused_d = pause && is_play(state_q) && is_play(state_d);
`else
        // Port kept for interface compatibility; feature compiled out.
        paused_d = pause & 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_GAMESTART;
            lives_q  <= '0;
            score_q  <= '0;
            spawn_q  <= '0;
            invuln_q <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            score_q  <= score_d;
            spawn_q  <= spawn_for(state_d);
            invuln_q <= (inv_nxt != '0);
            paused_q <= paused_d;
        end
    end

    // Next values of the level and fail counters are not needed outside
    // their own instances.
    logic unused_nxt;
    assign unused_nxt = ^{lvl_nxt, fail_nxt};

    assign state        = state_q;
    assign lives        = lives_q;
    assign score        = score_q;
    assign spawn_period = spawn_q;
    assign invuln       = invuln_q;
    assign paused       = paused_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed self-checking bench for game_sequencer.
// Latency: checks one cycle after each stimulus edge.
// Backpressure: none; inputs are pulses driven on the falling edge.
module tb_game_sequencer;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic        start;
    logic        hit;
    logic        pause;
    logic [3:0]  state;
    logic [1:0]  lives;
    logic [15:0] score;
    logic [7:0]  spawn_period;
    logic        invuln;
    logic        paused;

    int n_chk;
    int n_err;

    game_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .start        (start),
        .hit          (hit),
        .pause        (pause),
        .state        (state),
        .lives        (lives),
        .score        (score),
        .spawn_period (spawn_period),
        .invuln       (invuln),
        .paused       (paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; one call = one rising edge applied.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) cyc();
        frame_tick = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        cyc();
        hit = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        frame_tick = 1'b0;
        start = 1'b0;
        hit = 1'b0;
        pause = 1'b0;
        repeat (3) cyc();

        chk("rst_state",  state, 0);
        chk("rst_lives",  lives, 0);
        chk("rst_score",  score, 0);
        chk("rst_spawn",  spawn_period, 0);
        chk("rst_invuln", invuln, 0);
        chk("rst_paused", paused, 0);
        rst = 1'b0;
        cyc();

        // ticks and hits in GAMESTART are ignored
        frame_tick = 1'b1; hit = 1'b1;
        cyc();
        frame_tick = 1'b0; hit = 1'b0;
        chk("gs_ignore_state", state, 0);
        chk("gs_ignore_score", score, 0);

        pulse_start();
        chk("start_state", state, 1);
        chk("start_lives", lives, 3);
        chk("start_score", score, 0);
        chk("start_spawn", spawn_period, 60);
        pulse_start();
        chk("start_in_play_ign", state, 1);

        ticks(599);
        chk("easy_599_state", state, 1);
        chk("easy_599_score", score, 599);
        ticks(1);
        chk("normal_state", state, 2);
        chk("normal_spawn", spawn_period, 40);
        ticks(600);
        chk("hard_state", state, 3);
        chk("hard_spawn", spawn_period, 25);
        ticks(600);
        chk("inferno_state", state, 4);
        chk("inferno_spawn", spawn_period, 15);
        ticks(600);
        chk("inferno_stay", state, 4);
        chk("inferno_score", score, 2400);

        // invulnerability window
        pulse_hit();
        chk("hit1_lives", lives, 2);
        chk("hit1_invuln", invuln, 1);
        ticks(30);
        pulse_hit();
        chk("hit2_ignored", lives, 2);
        chk("hit2_invuln", invuln, 1);
        ticks(30);
        chk("invuln_expired", invuln, 0);
        pulse_hit();
        chk("hit3_lives", lives, 1);
        ticks(61);
        pulse_hit();
        chk("fatal_state", state, 5);
        chk("fatal_lives", lives, 0);
        chk("fatal_spawn", spawn_period, 0);
        chk("fatal_invuln", invuln, 0);
        chk("fatal_score", score, 2521);

        // failure hold
        ticks(50);
        chk("fail_score_hold", score, 2521);
        pulse_start();
        chk("fail_early_start", state, 5);
        ticks(70);
        pulse_start();
        chk("fail_to_gamestart", state, 0);
        chk("gs_lives_hold", lives, 0);
        chk("gs_score_hold", score, 2521);

        // immunity boundary and fatal hit on the escalation tick
        pulse_start();
        chk("g2_score_clr", score, 0);
        pulse_hit();
        chk("g2_hit_lives", lives, 2);
        ticks(59);
        chk("g2_inv_last", invuln, 1);
        frame_tick = 1'b1; hit = 1'b1;
        cyc();
        frame_tick = 1'b0; hit = 1'b0;
        chk("g2_tickhit_ign", lives, 2);
        chk("g2_inv_clear", invuln, 0);
        frame_tick = 1'b1; hit = 1'b1;
        cyc();
        frame_tick = 1'b0; hit = 1'b0;
        chk("g2_tickhit_take", lives, 1);
        ticks(538);
        chk("g2_pre_esc_state", state, 1);
        chk("g2_pre_esc_score", score, 599);
        frame_tick = 1'b1; hit = 1'b1;
        cyc();
        frame_tick = 1'b0; hit = 1'b0;
        chk("fatal_beats_esc", state, 5);
        chk("fatal_esc_lives", lives, 0);

        // async reset from FAILURE
        rst = 1'b1;
        #1;
        chk("async_rst_state", state, 0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("rst_fail_lives", lives, 0);
        chk("rst_fail_score", score, 0);

        pulse_start();
        ticks(5);
        chk("g3_score", score, 5);
`ifdef GAME_SEQUENCER_PAUSE_EN
        pause = 1'b1;
        cyc();
        chk("pause_set", paused, 1);
        frame_tick = 1'b1; hit = 1'b1;
        repeat (100) cyc();
        frame_tick = 1'b0; hit = 1'b0;
        chk("pause_score", score, 5);
        chk("pause_lives", lives, 3);
        chk("pause_state", state, 1);
        chk("pause_held", paused, 1);
        pause = 1'b0;
        cyc();
        chk("pause_release", paused, 0);
        ticks(3);
        chk("resume_score", score, 8);
`else
        pause = 1'b1;
        ticks(5);
        pause = 1'b0;
        chk("nopause_paused", paused, 0);
        chk("nopause_score", score, 10);
`endif

        // mid-game reset
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        chk("midgame_rst_state", state, 0);
        chk("midgame_rst_score", score, 0);
        chk("midgame_rst_lives", lives, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
